// File: rtl/t03_vga_timing.sv
// ---------------------------------------------------------------------------
// t03_vga_timing
//   VGA raster timing generator. A clock divider produces a one-clk pixel
//   tick. The horizontal/vertical counters advance on that tick and are
//   exported undelayed to the sprite blocks. hsync, vsync and blank are
//   decoded from the counters and then delayed by PIPE_DELAY pixel ticks.
//   That delay lines them up with sprite colour that is registered
//   downstream.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   run enable; while low, counters and divider are held
//   pix_en      out  one-clk pixel tick
//   Hcnt        out  horizontal pixel count, undelayed (11 bits)
//   Vcnt        out  vertical line count, undelayed (11 bits)
//   hsync       out  delayed horizontal sync, active level SYNC_POL
//   vsync       out  delayed vertical sync, active level SYNC_POL
//   blank       out  delayed blanking, 1 = outside the visible area
//   line_start  out  one-clk pulse on the tick that wraps Hcnt
//   frame_start out  one-clk pulse on the tick that wraps Hcnt and Vcnt
// ---------------------------------------------------------------------------
module t03_vga_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned PIPE_DELAY = 1,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pix_en,
  output logic [10:0] Hcnt,
  output logic [10:0] Vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          h_last;
  logic          v_last;
  logic          hs_raw;
  logic          vs_raw;
  logic          bl_raw;
  logic          hs_act;
  logic          vs_act;
  logic          bl_act;

  // Pixel clock divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (en) begin
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // rst gating keeps the tick low during reset when CLK_DIV=1 (div==0 is
  // then also the terminal value).
  always_comb begin
    pix_en = en & ~rst & (div == DIV_LAST);
  end

  // Raster counters
  always_comb begin
    h_last = (Hcnt == H_LAST);
    v_last = (Vcnt == V_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hcnt <= '0;
      Vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        Hcnt <= '0;
        if (v_last) begin
          Vcnt <= '0;
        end else begin
          Vcnt <= Vcnt + 11'd1;
        end
      end else begin
        Hcnt <= Hcnt + 11'd1;
      end
    end
  end

  always_comb begin
    line_start  = pix_en & h_last;
    frame_start = pix_en & h_last & v_last;
  end

  // Undelayed sync and blank decode, active-high internally
  always_comb begin
    hs_raw = (Hcnt >= HS_START) && (Hcnt < HS_END);
    vs_raw = (Vcnt >= VS_START) && (Vcnt < VS_END);
    bl_raw = (Hcnt >= H_VIS) || (Vcnt >= V_VIS);
  end

  // Sync and blank delay line, advancing on pixel ticks only
  generate
    if (PIPE_DELAY == 0) begin : g_nodelay
      always_comb begin
        hs_act = hs_raw & ~rst;
        vs_act = vs_raw & ~rst;
        bl_act = bl_raw | rst;
      end
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe;
      logic [PIPE_DELAY-1:0] vs_pipe;
      logic [PIPE_DELAY-1:0] bl_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hs_pipe <= '0;
          vs_pipe <= '0;
          bl_pipe <= '1;
        end else if (pix_en) begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          bl_pipe[0] <= bl_raw;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            bl_pipe[i] <= bl_pipe[i-1];
          end
        end
      end

      always_comb begin
        hs_act = hs_pipe[PIPE_DELAY-1];
        vs_act = vs_pipe[PIPE_DELAY-1];
        bl_act = bl_pipe[PIPE_DELAY-1];
      end
    end
  endgenerate

  // Pin polarity
  always_comb begin
    hsync = hs_act ? SYNC_POL : ~SYNC_POL;
    vsync = vs_act ? SYNC_POL : ~SYNC_POL;
    blank = bl_act;
  end

endmodule

// File: tb/tb_t03_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_t03_vga_timing
//   Three instances share one clk, rst and en:
//     u0  default parameters (640x480 raster, divide-by-4, 1-tick delay)
//     u1  small raster, CLK_DIV=1, PIPE_DELAY=3, active-high sync
//     u2  small raster, CLK_DIV=3, PIPE_DELAY=0
//   The reference model counts pixel ticks since reset. It derives the
//   raster position with modulo arithmetic. It derives the delayed
//   sync/blank from the position PIPE_DELAY ticks earlier.
// ---------------------------------------------------------------------------
module tb_t03_vga_timing;

  typedef struct packed {
    logic        pe;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef obs_t [2:0] trio_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic        pe [3];
  logic [10:0] hc [3];
  logic [10:0] vc [3];
  logic        hs [3];
  logic        vs [3];
  logic        bl [3];
  logic        ls [3];
  logic        fs [3];

  always #5 clk = ~clk;

  t03_vga_timing u0 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe[0]), .Hcnt(hc[0]), .Vcnt(vc[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank(bl[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  t03_vga_timing #(
    .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(1), .PIPE_DELAY(3), .SYNC_POL(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe[1]), .Hcnt(hc[1]), .Vcnt(vc[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank(bl[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  t03_vga_timing #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .CLK_DIV(3), .PIPE_DELAY(0), .SYNC_POL(1'b0)
  ) u2 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe[2]), .Hcnt(hc[2]), .Vcnt(vc[2]),
    .hsync(hs[2]), .vsync(vs[2]), .blank(bl[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  // Per-instance geometry, matching the instantiations above
  longint unsigned HA [3] = '{640, 10, 8};
  longint unsigned HF [3] = '{16, 2, 1};
  longint unsigned HS [3] = '{96, 3, 2};
  longint unsigned HB [3] = '{48, 5, 3};
  longint unsigned VA [3] = '{480, 6, 4};
  longint unsigned VF [3] = '{10, 1, 1};
  longint unsigned VS [3] = '{2, 2, 1};
  longint unsigned VB [3] = '{33, 3, 2};
  longint unsigned CD [3] = '{4, 1, 3};
  longint unsigned PD [3] = '{1, 3, 0};
  logic            SP [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: ticks since reset release and the divider phase
  longint unsigned p  [3] = '{0, 0, 0};
  longint unsigned ph [3] = '{0, 0, 0};

  trio_t sbq [$];
  int    total = 0;
  int    bad   = 0;
  bit    finished = 1'b0;

  function automatic longint unsigned htot(input int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic longint unsigned vtot(input int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic longint unsigned pos_h(input int k);
    return (p[k] % (htot(k) * vtot(k))) % htot(k);
  endfunction

  function automatic longint unsigned pos_v(input int k);
    return (p[k] % (htot(k) * vtot(k))) / htot(k);
  endfunction

  function automatic obs_t expect_obs(input int k, input logic r, input logic e);
    obs_t            o;
    longint unsigned ht, vt, fr, h, v, q, qh, qv;
    logic            hsa, vsa;
    ht = htot(k);
    vt = vtot(k);
    fr = ht * vt;
    if (r) begin
      o = '{pe: 1'b0, h: 11'd0, v: 11'd0, hs: ~SP[k], vs: ~SP[k],
            bl: 1'b1, ls: 1'b0, fs: 1'b0};
      return o;
    end
    h = pos_h(k);
    v = pos_v(k);
    o.pe = e && (ph[k] == CD[k] - 1);
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.ls = o.pe && (h == ht - 1);
    o.fs = o.ls && (v == vt - 1);
    if (p[k] < PD[k]) begin
      o.hs = ~SP[k];
      o.vs = ~SP[k];
      o.bl = 1'b1;
    end else begin
      q   = (p[k] - PD[k]) % fr;
      qh  = q % ht;
      qv  = q / ht;
      hsa = (qh >= HA[k] + HF[k]) && (qh < HA[k] + HF[k] + HS[k]);
      vsa = (qv >= VA[k] + VF[k]) && (qv < VA[k] + VF[k] + VS[k]);
      o.hs = hsa ? SP[k] : ~SP[k];
      o.vs = vsa ? SP[k] : ~SP[k];
      o.bl = (qh >= HA[k]) || (qv >= VA[k]);
    end
    return o;
  endfunction

  task automatic finish_run();
    if (!finished) begin
      finished = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // One clk cycle: advance the model on the edge, then drive the new
  // inputs and queue the outputs expected for this cycle.
  task automatic step(input logic r, input logic e);
    trio_t t;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        p[k]  = 0;
        ph[k] = 0;
      end else if (en) begin
        if (ph[k] == CD[k] - 1) begin
          p[k]  = p[k] + 1;
          ph[k] = 0;
        end else begin
          ph[k] = ph[k] + 1;
        end
      end
    end
    #1;
    rst = r;
    en  = e;
    for (int k = 0; k < 3; k++) begin
      t[k] = expect_obs(k, r, e);
    end
    sbq.push_back(t);
  endtask

  // Monitor: compares every queued cycle against the DUT outputs
  initial begin
    trio_t t;
    obs_t  a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        t = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          a = {pe[k], hc[k], vc[k], hs[k], vs[k], bl[k], ls[k], fs[k]};
          total++;
          if (a != t[k]) begin
            bad++;
            $display("FAIL sb_u%0d t=%0t got pe=%b h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b want pe=%b h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                     k, $time, a.pe, a.h, a.v, a.hs, a.vs, a.bl, a.ls, a.fs,
                     t[k].pe, t[k].h, t[k].v, t[k].hs, t[k].vs, t[k].bl, t[k].ls, t[k].fs);
          end
        end
        if (bad >= 20) finish_run();
      end
    end
  end

  initial begin
    int n;
    int len;

    repeat (3) step(1'b1, 1'b1);

    // First line and sync pulse of the default raster; stop at Hcnt=300 on line 1
    n = 0;
    while (p[0] < 1100 && n < 6000) begin
      step(1'b0, 1'b1);
      n++;
    end
    total++;
    if (n >= 6000) begin
      bad++;
      $display("FAIL reach_h300 got p=%0d want p=1100", p[0]);
    end

    // Freeze for 50 clks, then resume
    repeat (50) step(1'b0, 1'b0);
    repeat (400) step(1'b0, 1'b1);

    // Random enable gaps
    repeat (2000) step(1'b0, 1'($urandom_range(0, 3) != 0));

    // Reset pulse while u1 is inside both its hsync and vsync windows
    n = 0;
    while (!(pos_h(1) == 13 && pos_v(1) == 8) && n < 5000) begin
      step(1'b0, 1'b1);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL reach_sync_pos got h=%0d v=%0d want h=13 v=8", pos_h(1), pos_v(1));
    end
    len = int'($urandom_range(1, 4));
    repeat (len) step(1'b1, 1'b1);
    repeat (600) step(1'b0, 1'b1);

    // Random enable with occasional reset pulses
    repeat (3000) step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 4) != 0));
    repeat (1000) step(1'b0, 1'b1);

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got left=%0d want left=0", sbq.size());
    end
    finish_run();
  end

endmodule
